ps2_rx_frame: RTL
=================

// Module: ps2_rx_frame
// PURPOSE
//  Deserializes PS/2 device-to-host frames from the debounced PS/2 clock/data lines.
//  Sits directly downstream of the PS/2 debouncer. Feeds the keyboard peripheral
//  register block with one scan-code byte per frame, plus error flags.
//  Frame format: start(0), 8 data bits LSB first, odd parity, stop(1). Sampled on PS/2 clock falling edges.
// PARAMETERS
//  TIMEOUT_CYCLES  10000  clk_i cycles allowed between PS/2 falling edges inside a frame (used only with PS2_RX_TIMEOUT_EN)
// PORTS
//  clk_i          in   1  system clock; single clock domain
//  rst_i          in   1  asynchronous reset, active-low
//  ps2_clk_i      in   1  debounced PS/2 clock; already synchronous to clk_i
//  ps2_data_i     in   1  debounced PS/2 data; already synchronous to clk_i
//  data_o         out  8  last good scan code; held until next good frame
//  valid_o        out  1  one-cycle pulse: data_o updated
//  parity_err_o   out  1  one-cycle pulse: frame rejected, parity not odd
//  frame_err_o    out  1  one-cycle pulse: frame rejected, stop bit 0 or timeout
//  busy_o         out  1  high while FSM is not IDLE
// BEHAVIOUR
//  Reset values: data_o=8'h00; valid_o, parity_err_o, frame_err_o, busy_o = 0; FSM=IDLE; bit count=0.
//  - ps2_clk_prev resets to 1, so a line held low at reset release gives no false edge.
//  Edge detect: fall = ps2_clk_prev & ~ps2_clk_i. All FSM actions happen at the clk_i edge where fall=1.
//  - ps2_data_i is sampled at that same edge.
//  FSM:
//  - IDLE: on fall with data=0, go to DATA and clear bit count. On fall with data=1, stay in IDLE (spurious edge ignored).
//  - DATA: on fall, shift data into shreg[7] (right shift, LSB first) and increment the count. After the 8th bit, go to PARITY.
//  - PARITY: on fall, latch the parity bit and go to STOP.
//  - STOP: on fall, always return to IDLE. Outcome, in priority order:
//    - stop=0: frame_err_o=1.
//    - else ^{shreg,parity}==0: parity_err_o=1.
//    - else: data_o<=shreg and valid_o=1.
//  Latency: the pulse is high in the cycle after the edge where the stop-bit fall is seen. It lasts exactly 1 cycle.
//  - Only one of valid/parity_err/frame_err may be high in any cycle.
//  - On any error, data_o keeps its previous value.
//  No backpressure. The consumer must capture data_o on valid_o; the next frame is >= ~1 ms later.
//  Async reset mid-frame: return to IDLE at once. The partial frame is discarded and no pulse is issued.
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined:
//  - Counter of width $clog2(TIMEOUT_CYCLES) is cleared on every fall and while in IDLE.
//  - Outside IDLE, if it reaches TIMEOUT_CYCLES-1: FSM goes to IDLE, frame_err_o pulses once, the partial frame is discarded.
//  - A fall in the same cycle as expiry is handled as a fall and the timeout does not fire.
//  PS2_RX_TIMEOUT_EN undefined:
//  - No counter is instantiated and TIMEOUT_CYCLES is ignored.
//  - The FSM waits indefinitely for the next edge.
// STRUCTURE
//  Package ps2_pkg:
//  - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t
//  - localparam PS2_DATA_BITS = 8
//  - localparams PS2_START_BIT = 1'b0 and PS2_STOP_BIT = 1'b1
//  Sub-module ps2_fall_detect: registers ps2_clk_i (async reset to 1) and outputs the one-cycle fall strobe.
//  - It is reused by the future host-to-device transmitter.
//  FSM, shift register, counter and outputs live in ps2_rx_frame.
// TESTING
//  PS/2 clock period in the bench is 20 clk_i cycles.
//  1. Frame 0x1C (bits 0,00111000,p=0,1) -> data_o=8'h1C, valid_o high 1 cycle, no error pulses.
//  2. Frame 0x1C with p=1 -> parity_err_o 1-cycle pulse, valid_o=0, data_o keeps previous value.
//  3. Frame 0x5A (p=1) with stop=0 -> frame_err_o pulse; next frame 0x5A with stop=1 -> data_o=8'h5A, valid_o.
//  4. In IDLE, fall with data=1 -> busy_o stays 0, no pulses; a following good 0xF0 (p=1) frame is received correctly.
//  5. rst_i low after 4 data bits -> busy_o=0 at once, no pulses; after release, frame 0xF0 -> data_o=8'hF0.
//  6. PS2_RX_TIMEOUT_EN: clock stopped after 5 data bits -> frame_err_o once after TIMEOUT_CYCLES, busy_o=0.
//     - Then frame 0x5A -> valid_o. Without the macro: busy_o stays 1 and no pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path (and the future transmitter).
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

   localparam int   PS2_DATA_BITS = 8;
   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;

endpackage

// File: rtl/ps2_fall_detect.sv
// Falling-edge strobe for an already synchronous PS/2 clock line.
// The register resets high so a line held low at reset release gives no false edge.
module ps2_fall_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic fall
);

   logic line_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_prev <= 1'b1;
      end else begin
         line_prev <= line;
      end
   end

   assign fall = line_prev & ~line;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional inter-edge watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   ps2_rx_state_t state;
   logic          fall;
   logic [7:0]    shreg;
   logic          parity_bit;
   logic [3:0]    bit_cnt;
   logic          timeout_hit;

   generate
      if (TIMEOUT_CYCLES < 2) begin : g_param_check
         $error("ps2_rx_frame: TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   ps2_fall_detect u_fall (
      .clk   (clk_i),
      .rst_n (rst_i),
      .line  (ps2_clk_i),
      .fall  (fall)
   );

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] idle_cnt;

   // Watchdog restarts on every PS/2 falling edge; a fall in the expiry cycle wins.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idle_cnt <= '0;
      end else if (state == IDLE || fall) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state != IDLE) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         shreg        <= 8'h00;
         parity_bit   <= 1'b0;
         bit_cnt      <= 4'd0;
         data_o       <= 8'h00;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         if (timeout_hit) begin
            state       <= IDLE;
            frame_err_o <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (ps2_data_i == PS2_START_BIT) begin
                     state   <= DATA;
                     bit_cnt <= 4'd0;
                  end
               end
               DATA: begin
                  shreg   <= {ps2_data_i, shreg[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(PS2_DATA_BITS - 1)) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  parity_bit <= ps2_data_i;
                  state      <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  // Stop-bit error outranks parity; data_o only moves on a clean frame.
                  if (ps2_data_i != PS2_STOP_BIT) begin
                     frame_err_o <= 1'b1;
                  end else if (^{shreg, parity_bit} == 1'b0) begin
                     parity_err_o <= 1'b1;
                  end else begin
                     data_o  <= shreg;
                     valid_o <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy_o = (state != IDLE);

endmodule
